// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM encoding and a
// constant-foldable ceil(log2) used to size iteration counters.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // ceil(log2(v)), never less than 1 so a counter always has at least one bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division iteration on the magnitudes: shift {P,Q} left,
// add or subtract the divisor, and shift in the new quotient bit.
module nr_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_nxt_c,
  output logic [WIDTH-1:0] q_nxt_c
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] d_ext;

  assign p_sh  = {p[WIDTH-1:0], q[WIDTH-1]};
  assign d_ext = {1'b0, d};

  // |P| stays within the divisor range, so doubling it never flips its sign;
  // the pre-shift sign bit therefore selects add versus subtract.
  assign p_nxt_c = p[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
  assign q_nxt_c = {q[WIDTH-2:0], ~p_nxt_c[WIDTH]};

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: magnitudes are divided by non-restoring
// iteration, one quotient bit per cycle, then signs and special cases applied.
module booth_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = clog2(WIDTH);

  div_state_t state, state_nxt;

  logic [WIDTH:0]   p_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;
  logic             a_neg, b_neg, dz_r, ov_r;

  logic [WIDTH:0]   p_nxt_c;
  logic [WIDTH-1:0] q_nxt_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [WIDTH-1:0] rem_mag_c, quo_c, rem_c;
  logic             dz_c, ov_c;

  assign abs_a_c = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
  assign abs_b_c = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
  assign dz_c    = (divisor == '0);
  assign ov_c    = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .p       (p_r),
    .q       (q_r),
    .d       (d_r),
    .p_nxt_c (p_nxt_c),
    .q_nxt_c (q_nxt_c)
  );

  // Final correction and sign fix-up. With a zero divisor every step
  // subtracts nothing, so P ends holding |dividend| and the remainder
  // naturally reconstructs the original dividend.
  always_comb begin
    rem_mag_c = p_r[WIDTH] ? (p_r[WIDTH-1:0] + d_r) : p_r[WIDTH-1:0];
    quo_c     = (a_neg ^ b_neg) ? (WIDTH'(0) - q_r) : q_r;
    rem_c     = a_neg ? (WIDTH'(0) - rem_mag_c) : rem_mag_c;
    if (dz_r) begin
      quo_c = '1;
    end else if (ov_r) begin
      quo_c = {1'b1, {(WIDTH-1){1'b0}}};
      rem_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)                state_nxt = CALC;
      CALC: if (cnt == CW'(WIDTH - 1))   state_nxt = FIX;
      FIX:                               state_nxt = DONE;
      DONE: if (out_valid && out_ready)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state == DONE) && !(out_valid && out_ready);
      case (state)
        IDLE: if (in_valid) begin
          p_r   <= '0;
          q_r   <= abs_a_c;
          d_r   <= abs_b_c;
          cnt   <= '0;
          a_neg <= dividend[WIDTH-1];
          b_neg <= divisor[WIDTH-1];
          dz_r  <= dz_c;
          ov_r  <= ov_c;
        end
        CALC: begin
          p_r <= p_nxt_c;
          q_r <= q_nxt_c;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          quotient    <= quo_c;
          remainder   <= rem_c;
          div_by_zero <= dz_r;
          overflow    <= ov_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed and random checks of booth_divider (WIDTH=8) against an
// integer-arithmetic reference held in a scoreboard queue.
module tb_booth_divider;

  localparam int W   = 8;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         div_by_zero, overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  booth_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai, bi;
    ai   = int'($signed(a));
    bi   = int'($signed(b));
    e.dz = (bi == 0);
    e.ov = (ai == -128) && (bi == -1);
    if (e.dz) begin
      e.q = 8'hFF;
      e.r = a;
    end else begin
      e.q = 8'(ai / bi);
      e.r = 8'(ai % bi);
    end
    return e;
  endfunction

  // One full transaction: drive, measure latency, compare, optionally stall, handshake.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit check_lat);
    exp_t e;
    int   lat;
    int   guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    sb.push_back(model(a, b));
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    if (check_lat) chk("latency", 32'(lat), 32'(LAT));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("quotient", 32'(quotient), 32'(e.q));
      chk("remainder", 32'(remainder), 32'(e.r));
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      chk("overflow", 32'(overflow), 32'(e.ov));
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_quotient", 32'(quotient), 32'(e.q));
        chk("hold_remainder", 32'(remainder), 32'(e.r));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    corners[0] = 8'h00;
    corners[1] = 8'h80;
    corners[2] = 8'h7F;
    corners[3] = 8'hFF;
    corners[4] = 8'h01;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_flags", 32'({div_by_zero, overflow}), 32'd0);
    rst = 1'b0;

    run(8'd100, 8'd7, 0, 1'b1);
    run(-8'sd100, 8'd7, 0, 1'b1);
    run(8'd100, -8'sd7, 0, 1'b1);
    run(-8'sd100, -8'sd7, 0, 1'b1);
    run(8'h80, 8'hFF, 0, 1'b1);
    run(8'h80, 8'h01, 0, 1'b1);
    run(8'd5, 8'd0, 0, 1'b1);
    run(8'd100, 8'd7, 5, 1'b1);

    // Abort an operation mid-iteration
    in_valid = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", 32'({div_by_zero, overflow}), 32'd0);
    run(8'd127, 8'h80, 0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      run(pick(), pick(), $urandom_range(0, 1), 1'b1);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
